instr_issue_encoder: RTL and testbench

- Front end of the processor top; produces the 32-bit instruction stream the processor core consumes.
- Accepts symbolic operation requests (op, src1, src2, dst) over a valid/ready handshake and encodes each into the core's instruction word.
- Buffers encoded words in a FIFO and issues them with optional pacing; emits an all-zero NOP word when idle.

---
 rtl/instr_issue_encoder_pkg.sv | 69 ++++++
 rtl/instr_issue_encoder_fifo.sv | 46 ++++
 rtl/instr_issue_encoder.sv | 121 ++++++++++++
 tb/tb_instr_issue_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/instr_issue_encoder_pkg.sv
// Shared definitions for the instruction issue encoder: op enum, core opcodes,
// instruction field layout and encode helpers.
package instr_issue_encoder_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ABS = 4'd2,
        OP_NEG = 4'd3,
        OP_MAX = 4'd4,
        OP_MIN = 4'd5,
        OP_AVG = 4'd6,
        OP_NOT = 4'd7,
        OP_OR  = 4'd8,
        OP_AND = 4'd9,
        OP_XOR = 4'd10
    } op_e;

    localparam int unsigned OPC_W   = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned INSTR_W = 32;

    localparam int unsigned OPC_LSB  = 0;
    localparam int unsigned SRC1_LSB = 6;
    localparam int unsigned SRC2_LSB = 11;
    localparam int unsigned DST_LSB  = 16;
    localparam int unsigned PAR_BIT  = 31;

    localparam logic [OPC_W-1:0] OPC_ADD = 6'b000001;
    localparam logic [OPC_W-1:0] OPC_SUB = 6'b000110;
    localparam logic [OPC_W-1:0] OPC_ABS = 6'b001101;
    localparam logic [OPC_W-1:0] OPC_NEG = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_MAX = 6'b000111;
    localparam logic [OPC_W-1:0] OPC_MIN = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_AVG = 6'b001011;
    localparam logic [OPC_W-1:0] OPC_NOT = 6'b001111;
    localparam logic [OPC_W-1:0] OPC_OR  = 6'b000011;
    localparam logic [OPC_W-1:0] OPC_AND = 6'b000101;
    localparam logic [OPC_W-1:0] OPC_XOR = 6'b000010;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    function automatic logic is_unary(input op_e op);
        return (op == OP_ABS) || (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= 4'd10;
    endfunction

    // Opcode 0 is never produced for a legal op; it marks an invalid word.
    function automatic logic [OPC_W-1:0] opcode_of(input op_e op);
        case (op)
            OP_ADD:  return OPC_ADD;
            OP_SUB:  return OPC_SUB;
            OP_ABS:  return OPC_ABS;
            OP_NEG:  return OPC_NEG;
            OP_MAX:  return OPC_MAX;
            OP_MIN:  return OPC_MIN;
            OP_AVG:  return OPC_AVG;
            OP_NOT:  return OPC_NOT;
            OP_OR:   return OPC_OR;
            OP_AND:  return OPC_AND;
            OP_XOR:  return OPC_XOR;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/instr_issue_encoder_fifo.sv
// Synchronous FIFO with occupancy count, synchronous reset and clear.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 data_in,
    input  logic                         pop,
    output logic [W-1:0]                 data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign data_out = mem[rd_ptr];
    assign empty    = (count == '0);

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/instr_issue_encoder.sv
// Encodes symbolic op requests into 32-bit core instructions, queues and issues
// them with optional pacing. Optional: INSTR_PARITY_EN puts even parity in bit 31.
module instr_issue_encoder
    import instr_issue_encoder_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ISSUE_GAP = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [3:0]                   req_op,
    input  logic [4:0]                   req_src1,
    input  logic [4:0]                   req_src2,
    input  logic [4:0]                   req_dst,
    input  logic                         issue_en,
    input  logic                         flush,
    output logic [31:0]                  instr,
    output logic                         instr_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [7:0]                   bad_op_cnt,
    output logic [CNT_W-1:0]             issued_cnt
);
    localparam int unsigned GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_e;

    state_e             state, state_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               pop_c;
    logic               accept_c;
    logic               push_c;
    logic               empty;
    logic [31:0]        word_c;
    logic [31:0]        head_word;
    op_e                op;

    assign op        = op_e'(req_op);
    assign req_ready = !rst && !flush && (fifo_count < ($clog2(DEPTH+1))'(DEPTH));
    assign accept_c  = req_valid && req_ready;
    assign push_c    = accept_c && is_legal(req_op);

    // Encode at enqueue so the FIFO holds finished words.
    always_comb begin
        word_c = NOP_WORD;
        word_c[OPC_LSB  +: OPC_W] = opcode_of(op);
        word_c[SRC1_LSB +: REG_W] = req_src1;
        word_c[SRC2_LSB +: REG_W] = is_unary(op) ? '0 : req_src2;
        word_c[DST_LSB  +: REG_W] = req_dst;
`ifdef INSTR_PARITY_EN
        word_c[PAR_BIT] = ^word_c[PAR_BIT-1:0];
`endif
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (push_c),
        .data_in  (word_c),
        .pop      (pop_c),
        .data_out (head_word),
        .count    (fifo_count),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Pop is decided in the same cycle the queue becomes eligible, so a word
    // accepted at one edge can be issued at the next.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pop_c     = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
            gap_nxt   = '0;
        end else if (state == S_GAP) begin
            gap_nxt = gap_cnt - GAP_W'(1);
            if (gap_cnt <= GAP_W'(1)) begin
                state_nxt = S_IDLE;
            end
        end else if (!empty && issue_en) begin
            pop_c     = 1'b1;
            state_nxt = (ISSUE_GAP > 0) ? S_GAP : S_ISSUE;
            gap_nxt   = GAP_W'(ISSUE_GAP);
        end else begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            issued_cnt  <= '0;
            bad_op_cnt  <= '0;
        end else begin
            instr       <= pop_c ? head_word : NOP_WORD;
            instr_valid <= pop_c;
            issued_cnt  <= issued_cnt + CNT_W'(pop_c);
            if (accept_c && !is_legal(req_op) && (bad_op_cnt != 8'hFF)) begin
                bad_op_cnt <= bad_op_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_encoder.sv
// Directed self-checking bench for instr_issue_encoder (default and ISSUE_GAP=2 instances).
module tb_instr_issue_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, issue_en, flush, instr_valid;
    logic [3:0]  req_op;
    logic [4:0]  req_src1, req_src2, req_dst;
    logic [31:0] instr;
    logic [2:0]  fifo_count;
    logic [7:0]  bad_op_cnt;
    logic [15:0] issued_cnt;

    logic        g_rst, g_req_valid, g_req_ready, g_issue_en, g_flush, g_instr_valid;
    logic [3:0]  g_req_op;
    logic [4:0]  g_req_src1, g_req_src2, g_req_dst;
    logic [31:0] g_instr;
    logic [2:0]  g_fifo_count;
    logic [7:0]  g_bad_op_cnt;
    logic [15:0] g_issued_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    instr_issue_encoder #(.DEPTH(4), .ISSUE_GAP(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
        .issue_en(issue_en), .flush(flush), .instr(instr), .instr_valid(instr_valid),
        .fifo_count(fifo_count), .bad_op_cnt(bad_op_cnt), .issued_cnt(issued_cnt)
    );

    instr_issue_encoder #(.DEPTH(4), .ISSUE_GAP(2), .CNT_W(16)) dut_gap (
        .clk(clk), .rst(g_rst), .req_valid(g_req_valid), .req_ready(g_req_ready),
        .req_op(g_req_op), .req_src1(g_req_src1), .req_src2(g_req_src2), .req_dst(g_req_dst),
        .issue_en(g_issue_en), .flush(g_flush), .instr(g_instr), .instr_valid(g_instr_valid),
        .fifo_count(g_fifo_count), .bad_op_cnt(g_bad_op_cnt), .issued_cnt(g_issued_cnt)
    );

    // Expected word with the optional parity bit applied.
    function automatic logic [31:0] xw(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef INSTR_PARITY_EN
        r[31] = ^w[30:0];
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [3:0] op, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] d);
        req_valid = v; req_op = op; req_src1 = s1; req_src2 = s2; req_dst = d;
    endtask

    initial begin
        logic [6:0] gap_pat;
        rst = 1'b1; issue_en = 1'b0; flush = 1'b0;
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        g_rst = 1'b1; g_req_valid = 1'b0; g_req_op = 4'd0; g_req_src1 = 5'd0;
        g_req_src2 = 5'd1; g_req_dst = 5'd2; g_issue_en = 1'b0; g_flush = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_bad", 32'(bad_op_cnt), 32'd0);
        chk("rst_issued", 32'(issued_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Single ADD, issued at the edge after acceptance
        issue_en = 1'b1;
        set_req(1'b1, 4'd0, 5'd0, 5'd1, 5'd2);
        tick();
        req_valid = 1'b0;
        chk("add_pre_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("add_instr", instr, xw(32'h00020801));
        chk("add_valid", 32'(instr_valid), 32'd1);
        chk("add_issued", 32'(issued_cnt), 32'd1);
        tick();
        chk("add_nop", instr, 32'h0);
        chk("add_nop_valid", 32'(instr_valid), 32'd0);

        // XOR then NEG back to back; NEG has src2 zeroed
        set_req(1'b1, 4'd10, 5'd27, 5'd28, 5'd29);
        tick();
        set_req(1'b1, 4'd3, 5'd8, 5'd5, 5'd9);
        tick();
        req_valid = 1'b0;
        chk("xor_instr", instr, xw(32'h001DE6C2));
        tick();
        chk("neg_instr", instr, xw(32'h00090208));
        chk("neg_valid", 32'(instr_valid), 32'd1);
        tick();
        chk("neg_nop", 32'(instr_valid), 32'd0);
        chk("xorneg_issued", 32'(issued_cnt), 32'd3);

        // Stall and fill past capacity
        issue_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 4'd0, 5'(i), 5'd1, 5'd2);
            #1;
            chk($sformatf("fill_ready%0d", i), 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        req_valid = 1'b0;
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("stall_valid", 32'(instr_valid), 32'd0);
        issue_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain_instr%0d", i), instr, xw(32'h00020801 | (32'(i) << 6)));
            chk($sformatf("drain_valid%0d", i), 32'(instr_valid), 32'd1);
        end
        tick();
        chk("drain_nop", instr, 32'h0);
        chk("drain_nop_valid", 32'(instr_valid), 32'd0);
        chk("drain_issued", 32'(issued_cnt), 32'd7);

        // Illegal op: accepted, counted, never issued
        set_req(1'b1, 4'd12, 5'd1, 5'd2, 5'd3);
        #1;
        chk("bad_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("bad_cnt1", 32'(bad_op_cnt), 32'd1);
        chk("bad_count", 32'(fifo_count), 32'd0);
        tick();
        chk("bad_no_issue", 32'(instr_valid), 32'd0);
        chk("bad_issued", 32'(issued_cnt), 32'd7);
        req_valid = 1'b1;
        repeat (300) tick();
        req_valid = 1'b0;
        chk("bad_sat", 32'(bad_op_cnt), 32'd255);

        // Flush with three queued and a concurrent request
        issue_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 4'd1, 5'(i), 5'd1, 5'd2);
            tick();
        end
        chk("pre_flush_count", 32'(fifo_count), 32'd3);
        flush = 1'b1; issue_en = 1'b1;
        #1;
        chk("flush_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_instr", instr, 32'h0);
        chk("flush_issued", 32'(issued_cnt), 32'd7);
        tick();
        chk("post_flush_valid", 32'(instr_valid), 32'd0);

        // Pacing with ISSUE_GAP=2
        g_rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            g_req_valid = 1'b1; g_req_src1 = 5'(i);
            tick();
        end
        g_req_valid = 1'b0;
        chk("gap_count", 32'(g_fifo_count), 32'd3);
        g_issue_en = 1'b1;
        gap_pat = 7'b1001001;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("gap_valid%0d", i), 32'(g_instr_valid), 32'(gap_pat[6-i]));
        end
        chk("gap_issued", 32'(g_issued_cnt), 32'd3);
        chk("gap_last_word", g_instr, xw(32'h00020801 | (32'd2 << 6)));

        // Reset mid-operation drops queued words
        g_issue_en = 1'b0; g_req_valid = 1'b1;
        tick(); tick();
        g_req_valid = 1'b0; g_rst = 1'b1;
        tick();
        chk("midrst_count", 32'(g_fifo_count), 32'd0);
        chk("midrst_issued", 32'(g_issued_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
